// File: rtl/object_centroid_if.sv
// object_centroid_if: pixel stream in, centroid result out.
interface object_centroid_if #(
   parameter int COLOR_WIDTH = 10,
   parameter int DISP_WIDTH  = 11
);
   logic                   pixel_valid;
   logic [COLOR_WIDTH-1:0] red;
   logic [COLOR_WIDTH-1:0] green;
   logic [COLOR_WIDTH-1:0] blue;
   logic [DISP_WIDTH-1:0]  x_pos;
   logic [DISP_WIDTH-1:0]  y_pos;
   logic                   frame_end;
   logic [DISP_WIDTH-1:0]  x_obj;
   logic [DISP_WIDTH-1:0]  y_obj;
   logic                   obj_found;
   logic                   obj_update;
   logic                   overrun;
   modport master (
      output pixel_valid, red, green, blue, x_pos, y_pos, frame_end,
      input  x_obj, y_obj, obj_found, obj_update, overrun
   );
   modport slave (
      input  pixel_valid, red, green, blue, x_pos, y_pos, frame_end,
      output x_obj, y_obj, obj_found, obj_update, overrun
   );
endinterface

// File: rtl/object_centroid.sv
// object_centroid: per-frame colour-matched pixel centroid via parallel restoring dividers.
// Define OBJECT_CENTROID_HOLD_EN to keep the previous position when no object is found.
module object_centroid #(
   parameter int COLOR_WIDTH = 10,
   parameter int DISP_WIDTH  = 11,
   parameter int R_MIN       = 600,
   parameter int G_MAX       = 300,
   parameter int B_MAX       = 300,
   parameter int MIN_PIXELS  = 16
) (
   input logic clk,
   input logic reset,
   object_centroid_if.slave bus
);
   localparam int SW = 3 * DISP_WIDTH;
   localparam int CW = 2 * DISP_WIDTH;
   localparam int IW = $clog2(DISP_WIDTH);
`ifdef OBJECT_CENTROID_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, CHECK, DIVIDE, PUBLISH} state_t;

   state_t                state;
   logic [SW-1:0]         sum_x, sum_y, sum_x_n, sum_y_n, num_x, num_y, dsh;
   logic [CW-1:0]         cnt, cnt_n, div;
   logic [DISP_WIDTH-1:0] q_x, q_y, q_x_n, q_y_n, bit_m;
   logic [DISP_WIDTH-1:0] x_obj, y_obj;
   logic [IW-1:0]         idx;
   logic                  match, fx, fy, obj_found, obj_update, overrun;

   always_comb begin
      match = bus.pixel_valid && (bus.red > COLOR_WIDTH'(R_MIN)) &&
              (bus.green < COLOR_WIDTH'(G_MAX)) && (bus.blue < COLOR_WIDTH'(B_MAX));
      sum_x_n = sum_x + (match ? SW'(bus.x_pos) : '0);
      sum_y_n = sum_y + (match ? SW'(bus.y_pos) : '0);
      cnt_n   = cnt + CW'(match);
      dsh     = SW'(div) << idx;
      fx      = num_x >= dsh;
      fy      = num_y >= dsh;
      bit_m   = DISP_WIDTH'(1) << idx;
      q_x_n   = fx ? (q_x | bit_m) : q_x;
      q_y_n   = fy ? (q_y | bit_m) : q_y;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         sum_x      <= '0;
         sum_y      <= '0;
         cnt        <= '0;
         num_x      <= '0;
         num_y      <= '0;
         div        <= '0;
         q_x        <= '0;
         q_y        <= '0;
         idx        <= '0;
         x_obj      <= '0;
         y_obj      <= '0;
         obj_found  <= 1'b0;
         obj_update <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         // accumulators restart on every frame_end, whether the frame is kept or dropped
         sum_x      <= bus.frame_end ? '0 : sum_x_n;
         sum_y      <= bus.frame_end ? '0 : sum_y_n;
         cnt        <= bus.frame_end ? '0 : cnt_n;
         obj_update <= 1'b0;
         if (bus.frame_end && state != IDLE) overrun <= 1'b1;
         case (state)
            IDLE: if (bus.frame_end) begin
               num_x <= sum_x_n;
               num_y <= sum_y_n;
               div   <= cnt_n;
               state <= CHECK;
            end
            CHECK: if (div < CW'(MIN_PIXELS)) begin
               x_obj      <= HOLD ? x_obj : '0;
               y_obj      <= HOLD ? y_obj : '0;
               obj_found  <= 1'b0;
               obj_update <= 1'b1;
               state      <= PUBLISH;
            end else begin
               q_x   <= '0;
               q_y   <= '0;
               idx   <= IW'(DISP_WIDTH - 1);
               state <= DIVIDE;
            end
            DIVIDE: begin
               num_x <= fx ? num_x - dsh : num_x;
               num_y <= fy ? num_y - dsh : num_y;
               q_x   <= q_x_n;
               q_y   <= q_y_n;
               idx   <= idx - IW'(1);
               if (idx == '0) begin
                  x_obj      <= q_x_n;
                  y_obj      <= q_y_n;
                  obj_found  <= 1'b1;
                  obj_update <= 1'b1;
                  state      <= PUBLISH;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.x_obj      = x_obj;
   assign bus.y_obj      = y_obj;
   assign bus.obj_found  = obj_found;
   assign bus.obj_update = obj_update;
   assign bus.overrun    = overrun;
endmodule
